// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer: channel codes, select FSM states and
// the quadrature transition patterns ({sa, prev_a, sb, prev_b}) that count as steps.
package rgb_mixer_pkg;

   localparam logic [1:0] CH_R = 2'd0;
   localparam logic [1:0] CH_G = 2'd1;
   localparam logic [1:0] CH_B = 2'd2;

   typedef enum logic [1:0] {
      SEL_R = 2'd0,
      SEL_G = 2'd1,
      SEL_B = 2'd2
   } sel_state_e;

   localparam logic [3:0] QUAD_UP_A_RISE = 4'b1000;
   localparam logic [3:0] QUAD_UP_A_FALL = 4'b0111;
   localparam logic [3:0] QUAD_DN_B_RISE = 4'b0010;
   localparam logic [3:0] QUAD_DN_B_FALL = 4'b1101;

endpackage

// File: rtl/quad_step.sv
// Quadrature front end: 2-flop synchronizers on A/B, transition decode and
// registered one-cycle up/down step pulses.
module quad_step
   import rgb_mixer_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enc_a_i,
   input  logic enc_b_i,
   output logic step_up_o,
   output logic step_dn_o
);

   logic [1:0] sync_a_q, sync_b_q;
   logic       prev_a_q, prev_b_q;
   logic       up_q, dn_q;
   logic       sa, sb;
   logic [3:0] pattern;
   logic       up_d, dn_d;

   assign sa = sync_a_q[1];
   assign sb = sync_b_q[1];

   always_comb begin
      pattern = {sa, prev_a_q, sb, prev_b_q};
      up_d    = (pattern == QUAD_UP_A_RISE) || (pattern == QUAD_UP_A_FALL);
      dn_d    = (pattern == QUAD_DN_B_RISE) || (pattern == QUAD_DN_B_FALL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
         prev_a_q <= 1'b0;
         prev_b_q <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
      end else begin
         sync_a_q <= {sync_a_q[0], enc_a_i};
         sync_b_q <= {sync_b_q[0], enc_b_i};
         prev_a_q <= sa;
         prev_b_q <= sb;
         up_q     <= up_d;
         dn_q     <= dn_d;
      end
   end

   assign step_up_o = up_q;
   assign step_dn_o = dn_q;

endmodule

// File: rtl/rgb_channel_ctrl.sv
// One encoder + one button driving three saturating colour registers.
// Define RGB_CTRL_ACCEL_EN to enable step acceleration for fast same-direction turns.
module rgb_channel_ctrl
   import rgb_mixer_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned STEP            = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned ACCEL_WINDOW    = 1024,
   parameter int unsigned ACCEL_STEP      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a_i,
   input  logic             enc_b_i,
   input  logic             btn_i,
   output logic [1:0]       sel_o,
   output logic [WIDTH-1:0] red_o,
   output logic [WIDTH-1:0] green_o,
   output logic [WIDTH-1:0] blue_o,
   output logic             step_up_o,
   output logic             step_dn_o
);

   localparam int unsigned    DbW     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [WIDTH:0] StepAmt = (WIDTH + 1)'(STEP);

   quad_step u_quad_step (
      .clk       (clk),
      .reset     (reset),
      .enc_a_i   (enc_a_i),
      .enc_b_i   (enc_b_i),
      .step_up_o (step_up_o),
      .step_dn_o (step_dn_o)
   );

   // Button debounce
   logic [1:0]     sync_btn_q;
   logic           sbtn;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic           db_lvl_q, db_lvl_d, db_lvl_prev_q;
   logic           press;

   assign sbtn  = sync_btn_q[1];
   assign press = db_lvl_q & ~db_lvl_prev_q;

   always_comb begin
      db_cnt_d = '0;
      db_lvl_d = db_lvl_q;
      if (sbtn != db_lvl_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
            db_lvl_d = ~db_lvl_q;
         end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
         end
      end
   end

   // Select FSM
   sel_state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= SEL_R;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (press) begin
         unique case (state_q)
            SEL_R:   state_d = SEL_G;
            SEL_G:   state_d = SEL_B;
            SEL_B:   state_d = SEL_R;
            default: state_d = SEL_R;
         endcase
      end
   end

   always_comb begin
      sel_o = CH_R;
      unique case (state_q)
         SEL_R:   sel_o = CH_R;
         SEL_G:   sel_o = CH_G;
         SEL_B:   sel_o = CH_B;
         default: sel_o = CH_R;
      endcase
   end

   // Step size selection
   logic           step_any;
   logic [WIDTH:0] amt;

   assign step_any = step_up_o | step_dn_o;

`ifdef RGB_CTRL_ACCEL_EN
   localparam int unsigned    AccW     = $clog2(ACCEL_WINDOW + 1);
   localparam logic [WIDTH:0] AccelAmt = (WIDTH + 1)'(ACCEL_STEP);

   logic [AccW-1:0] acc_cnt_q, acc_cnt_d;
   logic            last_dir_q, last_dir_d;
   logic            last_vld_q, last_vld_d;
   logic            accel;

   always_comb begin
      accel      = last_vld_q && (last_dir_q == step_up_o) &&
                   (acc_cnt_q < AccW'(ACCEL_WINDOW));
      amt        = accel ? AccelAmt : StepAmt;
      acc_cnt_d  = acc_cnt_q;
      last_dir_d = last_dir_q;
      last_vld_d = last_vld_q;
      if (step_any) begin
         acc_cnt_d  = '0;
         last_dir_d = step_up_o;
         last_vld_d = 1'b1;
      end else if (acc_cnt_q != AccW'(ACCEL_WINDOW)) begin
         acc_cnt_d = acc_cnt_q + AccW'(1);
      end
      // A channel change means the next step starts slow again
      if (press) last_vld_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_cnt_q  <= '0;
         last_dir_q <= 1'b0;
         last_vld_q <= 1'b0;
      end else begin
         acc_cnt_q  <= acc_cnt_d;
         last_dir_q <= last_dir_d;
         last_vld_q <= last_vld_d;
      end
   end
`else
   logic unused_accel_cfg;
   assign unused_accel_cfg = ^{ACCEL_WINDOW, ACCEL_STEP};
   assign amt = StepAmt;
`endif

   // Saturating colour registers; the step always lands on the channel selected this cycle
   logic [WIDTH-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic [WIDTH-1:0] cur, nxt;
   logic [WIDTH:0]   sum, diff;

   always_comb begin
      case (state_q)
         SEL_G:   cur = green_q;
         SEL_B:   cur = blue_q;
         default: cur = red_q;
      endcase
      sum  = {1'b0, cur} + amt;
      diff = {1'b0, cur} - amt;
      nxt  = cur;
      if (step_up_o)      nxt = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
      else if (step_dn_o) nxt = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      if (step_any) begin
         case (state_q)
            SEL_G:   green_d = nxt;
            SEL_B:   blue_d  = nxt;
            default: red_d   = nxt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_btn_q    <= '0;
         db_cnt_q      <= '0;
         db_lvl_q      <= 1'b0;
         db_lvl_prev_q <= 1'b0;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
      end else begin
         sync_btn_q    <= {sync_btn_q[0], btn_i};
         db_cnt_q      <= db_cnt_d;
         db_lvl_q      <= db_lvl_d;
         db_lvl_prev_q <= db_lvl_q;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
      end
   end

   assign red_o   = red_q;
   assign green_o = green_q;
   assign blue_o  = blue_q;

endmodule

// File: tb/tb_rgb_channel_ctrl.sv
// Directed bench for rgb_channel_ctrl (default parameters); the accelerated build
// (RGB_CTRL_ACCEL_EN) runs the acceleration scenarios instead of the main sequence.
module tb_rgb_channel_ctrl;

   logic       clk = 1'b0;
   logic       reset, enc_a, enc_b, btn;
   logic [1:0] sel;
   logic [7:0] red, green, blue;
   logic       step_up, step_dn;

   int n_cmp = 0;
   int n_err = 0;
   int up_seen = 0;
   int dn_seen = 0;
   int u0, d0;

   rgb_channel_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .enc_a_i   (enc_a),
      .enc_b_i   (enc_b),
      .btn_i     (btn),
      .sel_o     (sel),
      .red_o     (red),
      .green_o   (green),
      .blue_o    (blue),
      .step_up_o (step_up),
      .step_dn_o (step_dn)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (step_up) up_seen++;
      if (step_dn) dn_seen++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One detent = both lines toggle; A first is an up step, B first is a down step
   task automatic detent(input bit up);
      if (up) enc_a = ~enc_a;
      else    enc_b = ~enc_b;
      tick(3);
      if (up) enc_b = ~enc_b;
      else    enc_a = ~enc_a;
      tick(3);
   endtask

   task automatic press();
      btn = 1'b1;
      tick(20);
      btn = 1'b0;
      tick(22);
   endtask

   initial begin
      reset = 1'b1;
      enc_a = 1'b0;
      enc_b = 1'b0;
      btn   = 1'b0;
      tick(3);
      check("rst_red", red, 0);
      check("rst_green", green, 0);
      check("rst_blue", blue, 0);
      check("rst_sel", sel, 0);
      check("rst_step_up", step_up, 0);
      check("rst_step_dn", step_dn, 0);
      reset = 1'b0;
      tick(2);

`ifdef RGB_CTRL_ACCEL_EN
      detent(1'b1);
      tick(100);
      detent(1'b1);
      tick(100);
      detent(1'b1);
      tick(4);
      check("accel_fast_red", red, 17);

      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);
      check("accel_rst_red", red, 0);
      detent(1'b1);
      tick(2000);
      detent(1'b1);
      tick(2000);
      detent(1'b1);
      tick(4);
      check("accel_slow_red", red, 3);
`else
      // Five up detents on red
      u0 = up_seen;
      for (int i = 0; i < 5; i++) detent(1'b1);
      tick(2);
      check("up5_red", red, 5);
      check("up5_green", green, 0);
      check("up5_blue", blue, 0);
      check("up5_sel", sel, 0);
      check("up5_pulses", up_seen - u0, 5);

      // Select green, three down detents clamp at 0
      press();
      check("press1_sel", sel, 1);
      d0 = dn_seen;
      for (int i = 0; i < 3; i++) detent(1'b0);
      tick(2);
      check("dn_green_clamp", green, 0);
      check("dn_pulses", dn_seen - d0, 3);
      check("dn_red_kept", red, 5);

      // Select blue, preload 254, then saturate at 255
      press();
      check("press2_sel", sel, 2);
      for (int i = 0; i < 254; i++) detent(1'b1);
      check("blue_preload", blue, 254);
      u0 = up_seen;
      for (int i = 0; i < 4; i++) detent(1'b1);
      check("blue_sat", blue, 255);
      check("sat_pulses", up_seen - u0, 4);

      // Short glitch is rejected
      btn = 1'b1;
      tick(10);
      btn = 1'b0;
      tick(30);
      check("glitch_sel", sel, 2);

      press();
      check("wrap_sel", sel, 0);
      for (int i = 0; i < 3; i++) begin
         press();
         check("cycle_sel", sel, (i + 1) % 3);
      end

      // Step arrives at the same edge as the select advance
      btn = 1'b1;
      tick(15);
      enc_a = ~enc_a;
      tick(3);
      check("align_pulse", step_up, 1);
      check("align_sel_old", sel, 0);
      check("align_red_before", red, 5);
      tick(1);
      check("align_sel_new", sel, 1);
      check("align_red_after", red, 6);
      check("align_green", green, 0);
      enc_b = ~enc_b;
      tick(3);
      btn = 1'b0;
      tick(22);

      // Back to red, bring it to 40, then reset during a debounce
      press();
      press();
      check("back_to_red", sel, 0);
      for (int i = 0; i < 34; i++) detent(1'b1);
      check("red40", red, 40);
      btn = 1'b1;
      tick(8);
      reset = 1'b1;
      tick(1);
      check("midrst_red", red, 0);
      check("midrst_green", green, 0);
      check("midrst_blue", blue, 0);
      check("midrst_sel", sel, 0);
      check("midrst_step_up", step_up, 0);
      check("midrst_step_dn", step_dn, 0);
      reset = 1'b0;
      btn   = 1'b0;
      tick(30);
      check("post_rst_sel", sel, 0);
      check("post_rst_red", red, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rgb_channel_ctrl.md
# rgb_channel_ctrl

Single-encoder channel controller for the RGB mixer. It takes one raw quadrature encoder and one raw push-button, and steers encoder steps into one of three saturating colour registers (red, green, blue). The button cycles the selected channel. The block sits between the board I/O pins and the PWM generators, replacing three independent per-channel encoder instances.

## Interface
Parameters:
- WIDTH, 8: bits per colour register.
- STEP, 1: base increment/decrement per detent.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles needed to accept a button level change; must be ≥2.
- ACCEL_WINDOW, 1024: cycle window for acceleration; used only with RGB_CTRL_ACCEL_EN.
- ACCEL_STEP, 8: accelerated increment; used only with RGB_CTRL_ACCEL_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enc_a  in  1  raw quadrature A, asynchronous.
- enc_b  in  1  raw quadrature B, asynchronous.
- btn  in  1  raw push-button, active-high, asynchronous.
- sel  out  2  selected channel: 0=R, 1=G, 2=B. Value 3 is never driven.
- red  out  WIDTH  red level.
- green  out  WIDTH  green level.
- blue  out  WIDTH  blue level.
- step_up  out  1  one-cycle pulse for each accepted up step (debug/LED).
- step_dn  out  1  one-cycle pulse for each accepted down step.

## Operation
- Reset:
  - red, green and blue clear to 0.
  - sel clears to 0 (R); step_up and step_dn clear to 0.
  - Synchronizers, debounce counter, debounced level and previous A/B samples all clear to 0.
- Synchronization: enc_a, enc_b and btn each pass through a 2-flop synchronizer. All decoding uses only the synchronized values (sa, sb, sbtn).
- Quadrature decode compares {sa, prev_a, sb, prev_b}:
  - 1000 → up.
  - 0111 → up.
  - 0010 → down.
  - 1101 → down.
  - Any other pattern, including A and B changing together, produces no step.
- Step application: the selected register changes by STEP and saturates.
  - Up steps clamp at 2^WIDTH−1; down steps clamp at 0. There is no wrap-around.
  - Arithmetic is done at WIDTH+1 bits before clamping.
  - step_up and step_dn still pulse on a saturated, no-change step.
- Button debounce:
  - The counter resets whenever sbtn equals the current debounced level.
  - The counter increments while sbtn differs from the debounced level.
  - On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Selection FSM: states SEL_R → SEL_G → SEL_B → SEL_R.
  - The state advances only on a rising edge of the debounced level.
  - A release (falling edge) has no effect.
- Simultaneous events: a step and a select advance in the same cycle apply the step to the old channel. The new sel takes effect from the next cycle.
- Reset mid-operation overrides everything, including a pending debounce count or a step in flight.

## Timing
- Encoder path: an A/B edge first sampled at rising edge N produces:
  - step_up or step_dn high after edge N+2;
  - the colour register updated at edge N+3.
- Button path: with btn stable from edge N, the debounced level rises at edge N+1+DEBOUNCE_CYCLES. sel updates one edge later.
- Steady state: one step is accepted per cycle at most; there are no stalls and no backpressure.
- All outputs are registered.

## Configuration
- RGB_CTRL_ACCEL_EN defined:
  - A cycle counter, saturating at ACCEL_WINDOW, restarts on every accepted step.
  - A step gets ACCEL_STEP instead of STEP when both hold: it is in the same direction as the previous step, and the counter is below ACCEL_WINDOW.
  - A direction change, a select change or reset cancels acceleration for the next step.
- RGB_CTRL_ACCEL_EN undefined: every step uses STEP, the acceleration counter is absent, and ACCEL_* are ignored.

## Structure
- Shared package rgb_mixer_pkg holds:
  - the channel-select encoding constants (CH_R=0, CH_G=1, CH_B=2);
  - the sel FSM state typedef;
  - the quadrature pattern constants.
- Sub-module quad_step: contains the synchronizer for A and B plus the decode, and outputs registered step_up and step_dn.
- The button debounce, select FSM, saturating registers and acceleration logic all live in rgb_channel_ctrl.

## Test plan
- Reset, then 5 clean up detents (A leads B) with WIDTH=8 and STEP=1 → red=5; green=0, blue=0; sel=0.
- Press btn held 20 cycles, then 3 down detents starting from green=0 → sel=1; green stays 0 (clamped); step_dn pulses 3 times.
- Preload blue=254 using sel=2, then 4 up detents → blue=255 with no wrap.
- btn glitch high for 10 cycles (below DEBOUNCE_CYCLES=16) → sel unchanged.
- Three full presses → sel cycles 0→1→2→0.
- Step edge aligned with the debounced rising edge → step lands on the old channel; sel advances one cycle later.
- Assert reset for 1 cycle mid-debounce with red=40 → all outputs 0; the pending press is discarded.
- Build with RGB_CTRL_ACCEL_EN, ACCEL_WINDOW=1024, ACCEL_STEP=8, and give 3 up detents 100 cycles apart → red=1+8+8=17.
- Same build, detents 2000 cycles apart → red=3.
